// File: rtl/reset_sequencer_if.sv
// reset_sequencer_if: groups the lock/soft-reset inputs and the staged reset
// outputs of reset_sequencer. The DUT side uses the slave modport.
//
// Signal semantics (no valid/ready pair here): lock is asynchronous and is
// synchronized inside the sequencer; sw_rst is a level sampled on every
// clock edge, so a single-cycle pulse or a held level are both legal.
// rst_out/done/timeout/state are registered outputs.
interface reset_sequencer_if #(
    parameter int STAGES = 3
) ();
    logic              lock;
    logic              sw_rst;
    logic [STAGES-1:0] rst_out;
    logic              done;
    logic              timeout;
    logic [2:0]        state;

    modport master (
        output lock,
        output sw_rst,
        input  rst_out,
        input  done,
        input  timeout,
        input  state
    );

    modport slave (
        input  lock,
        input  sw_rst,
        output rst_out,
        output done,
        output timeout,
        output state
    );
endinterface

// File: rtl/reset_sequencer.sv
// reset_sequencer: releases STAGES active-high resets (PHY, MAC, core/CSR)
// one at a time, in ascending bit order, once the synchronized PLL lock has
// been stable for HOLD_CYCLES edges, with STEP_CYCLES edges between stages.
// Lock loss or a soft reset re-asserts every output. All outputs are
// registered. The FSM state is visible on bus.state for debug.
//
// Optional build macro RESET_SEQ_WDOG_EN adds a lock-wait watchdog that sets
// a sticky timeout flag after WDOG_CYCLES consecutive edges in WAIT_LOCK.
module reset_sequencer #(
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYCLES = 16,
    parameter int STAGES      = 3,
    parameter int STEP_CYCLES = 4,
    parameter int WDOG_CYCLES = 1024
) (
    input  logic               c,
    input  logic               clr_n,
    reset_sequencer_if.slave   bus
);

    localparam logic [2:0] ST_ASSERT    = 3'd0;
    localparam logic [2:0] ST_WAIT_LOCK = 3'd1;
    localparam logic [2:0] ST_HOLD      = 3'd2;
    localparam logic [2:0] ST_RELEASE   = 3'd3;
    localparam logic [2:0] ST_RUN       = 3'd4;

    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam int STEP_W = $clog2(STEP_CYCLES + 1);
    localparam int IDX_W  = (STAGES > 1) ? $clog2(STAGES) : 1;

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_CYCLES - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(STAGES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   lock_s;

    logic [2:0]        state_q;
    logic [STAGES-1:0] rst_q;
    logic              done_q;
    logic [HOLD_W-1:0] hold_cnt;
    logic [STEP_W-1:0] step_cnt;
    logic [IDX_W-1:0]  idx_q;

    // Lock synchronizer: shift the asynchronous lock through SYNC_STAGES flops.
    always_ff @(posedge c or negedge clr_n) begin
        if (!clr_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.lock};
        end
    end

    assign lock_s = sync_q[SYNC_STAGES-1];

    // Sequencer FSM: soft reset wins over everything, lock loss re-arms the wait.
    always_ff @(posedge c or negedge clr_n) begin
        if (!clr_n) begin
            state_q  <= ST_ASSERT;
            rst_q    <= '1;
            done_q   <= 1'b0;
            hold_cnt <= '0;
            step_cnt <= '0;
            idx_q    <= '0;
        end else if (bus.sw_rst) begin
            state_q  <= ST_ASSERT;
            rst_q    <= '1;
            done_q   <= 1'b0;
            hold_cnt <= '0;
            step_cnt <= '0;
            idx_q    <= '0;
        end else begin
            case (state_q)
                ST_ASSERT: begin
                    state_q <= ST_WAIT_LOCK;
                    rst_q   <= '1;
                    done_q  <= 1'b0;
                end
                ST_WAIT_LOCK: begin
                    if (lock_s) begin
                        state_q  <= ST_HOLD;
                        hold_cnt <= '0;
                    end
                end
                ST_HOLD: begin
                    if (!lock_s) begin
                        // Lock glitch during hold-off: restart the wait, outputs untouched.
                        state_q  <= ST_WAIT_LOCK;
                        hold_cnt <= '0;
                    end else if (hold_cnt == HOLD_LAST) begin
                        rst_q[0] <= 1'b0;
                        hold_cnt <= '0;
                        step_cnt <= '0;
                        if (STAGES == 1) begin
                            state_q <= ST_RUN;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_RELEASE;
                            idx_q   <= IDX_W'(1);
                        end
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                ST_RELEASE: begin
                    if (!lock_s) begin
                        state_q  <= ST_WAIT_LOCK;
                        rst_q    <= '1;
                        done_q   <= 1'b0;
                        step_cnt <= '0;
                        idx_q    <= '0;
                    end else if (step_cnt == STEP_LAST) begin
                        // Exactly one stage clears per step, lowest index first.
                        rst_q[idx_q] <= 1'b0;
                        step_cnt     <= '0;
                        if (idx_q == IDX_LAST) begin
                            state_q <= ST_RUN;
                            done_q  <= 1'b1;
                            idx_q   <= '0;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end else begin
                        step_cnt <= step_cnt + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (!lock_s) begin
                        state_q  <= ST_WAIT_LOCK;
                        rst_q    <= '1;
                        done_q   <= 1'b0;
                        hold_cnt <= '0;
                        step_cnt <= '0;
                        idx_q    <= '0;
                    end else begin
                        rst_q  <= '0;
                        done_q <= 1'b1;
                    end
                end
                default: begin
                    state_q  <= ST_ASSERT;
                    rst_q    <= '1;
                    done_q   <= 1'b0;
                    hold_cnt <= '0;
                    step_cnt <= '0;
                    idx_q    <= '0;
                end
            endcase
        end
    end

    assign bus.rst_out = rst_q;
    assign bus.done    = done_q;
    assign bus.state   = state_q;

`ifdef RESET_SEQ_WDOG_EN
    localparam int WD_W = $clog2(WDOG_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(WDOG_CYCLES - 1);
    localparam logic [WD_W-1:0] WD_MAX  = WD_W'(WDOG_CYCLES);

    logic [WD_W-1:0] wd_cnt;
    logic            timeout_q;

    // Lock-wait watchdog: counts edges spent waiting, flags a sticky timeout.
    always_ff @(posedge c or negedge clr_n) begin
        if (!clr_n) begin
            wd_cnt    <= '0;
            timeout_q <= 1'b0;
        end else if (bus.sw_rst) begin
            wd_cnt    <= '0;
            timeout_q <= 1'b0;
        end else if ((state_q == ST_WAIT_LOCK) && !lock_s) begin
            if (wd_cnt != WD_MAX) begin
                wd_cnt <= wd_cnt + 1'b1;
            end
            if (wd_cnt == WD_LAST) begin
                timeout_q <= 1'b1;
            end
        end else begin
            wd_cnt <= '0;
        end
    end

    assign bus.timeout = timeout_q;
`else
    // No watchdog: the flag is constant 0 (WDOG_CYCLES is never negative).
    assign bus.timeout = (WDOG_CYCLES < 0);
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: directed bench for reset_sequencer with SYNC_STAGES=2,
// HOLD_CYCLES=16, STAGES=3, STEP_CYCLES=4, WDOG_CYCLES=8. Covers the
// power-up sequence, lock glitch in hold-off, lock loss in RUN, soft reset
// (pulse, held, and coincident with lock loss), a short async CLR_N pulse,
// and the watchdog flag (expected 1 only when RESET_SEQ_WDOG_EN is defined).
module tb_reset_sequencer;

    localparam int STAGES = 3;

    localparam logic [2:0] ST_ASSERT    = 3'd0;
    localparam logic [2:0] ST_WAIT_LOCK = 3'd1;
    localparam logic [2:0] ST_HOLD      = 3'd2;
    localparam logic [2:0] ST_RELEASE   = 3'd3;
    localparam logic [2:0] ST_RUN       = 3'd4;

`ifdef RESET_SEQ_WDOG_EN
    localparam logic WDOG_ON = 1'b1;
`else
    localparam logic WDOG_ON = 1'b0;
`endif

    logic c;
    logic clr_n;
    int   total = 0;
    int   bad   = 0;

    logic [STAGES:0] exp_q[$];

    reset_sequencer_if #(.STAGES(STAGES)) bus ();

    reset_sequencer #(
        .SYNC_STAGES(2),
        .HOLD_CYCLES(16),
        .STAGES     (STAGES),
        .STEP_CYCLES(4),
        .WDOG_CYCLES(8)
    ) dut (
        .c    (c),
        .clr_n(clr_n),
        .bus  (bus)
    );

    // Clock: 10 time-unit period, first rising edge at t=5.
    initial begin
        c = 1'b0;
        forever #5 c = ~c;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge c);
        #1;
    endtask

    task automatic drive_lock(input logic v);
        bus.lock = v;
    endtask

    task automatic drive_sw(input logic v);
        bus.sw_rst = v;
    endtask

    task automatic check_outs(input string tag, input logic [STAGES-1:0] rst,
                              input logic dn, input logic [2:0] st);
        chk({tag, "_rst"},   32'(bus.rst_out), 32'(rst));
        chk({tag, "_done"},  32'(bus.done),    32'(dn));
        chk({tag, "_state"}, 32'(bus.state),   32'(st));
    endtask

    // Called right after the edge that entered HOLD; walks 24 edges to RUN.
    task automatic run_seq(input string tag, input logic exp_to);
        logic [STAGES:0] e;
        exp_q.delete();
        for (int k = 1; k <= 24; k++) begin
            if (k < 16)      exp_q.push_back({1'b0, 3'b111});
            else if (k < 20) exp_q.push_back({1'b0, 3'b110});
            else if (k < 24) exp_q.push_back({1'b0, 3'b100});
            else             exp_q.push_back({1'b1, 3'b000});
        end
        for (int k = 1; k <= 24; k++) begin
            tick();
            e = exp_q.pop_front();
            chk($sformatf("%s_k%0d", tag, k), 32'({bus.done, bus.rst_out}), 32'(e));
        end
        chk({tag, "_run_state"}, 32'(bus.state),   32'(ST_RUN));
        chk({tag, "_timeout"},   32'(bus.timeout), 32'(exp_to));
    endtask

    task automatic advance(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        drive_lock(1'b1);
        drive_sw(1'b0);
        clr_n = 1'b1;
        #1 clr_n = 1'b0;
        #1;
        check_outs("reset", 3'b111, 1'b0, ST_ASSERT);
        chk("reset_timeout", 32'(bus.timeout), 32'(0));
        #1 clr_n = 1'b1;

        // Power-up: lock already high, HOLD entered at edge 3.
        tick(); check_outs("t1_e1", 3'b111, 1'b0, ST_WAIT_LOCK);
        tick(); check_outs("t1_e2", 3'b111, 1'b0, ST_WAIT_LOCK);
        tick(); check_outs("t1_e3", 3'b111, 1'b0, ST_HOLD);
        run_seq("t1", 1'b0);

        // Held soft reset stays in ASSERT, then restart.
        drive_sw(1'b1);
        tick(); check_outs("t2_sw1", 3'b111, 1'b0, ST_ASSERT);
        tick(); check_outs("t2_sw2", 3'b111, 1'b0, ST_ASSERT);
        tick(); check_outs("t2_sw3", 3'b111, 1'b0, ST_ASSERT);
        drive_sw(1'b0);
        tick(); check_outs("t2_wait", 3'b111, 1'b0, ST_WAIT_LOCK);
        tick(); check_outs("t2_hold", 3'b111, 1'b0, ST_HOLD);
        // One-cycle lock glitch at hold count 10.
        advance(10);
        check_outs("t2_k10", 3'b111, 1'b0, ST_HOLD);
        drive_lock(1'b0);
        tick();
        drive_lock(1'b1);
        tick(); check_outs("t2_k12", 3'b111, 1'b0, ST_HOLD);
        tick(); check_outs("t2_k13", 3'b111, 1'b0, ST_WAIT_LOCK);
        tick(); check_outs("t2_k14", 3'b111, 1'b0, ST_HOLD);
        run_seq("t2", 1'b0);

        // Lock loss in RUN: outputs re-assert SYNC_STAGES+1 edges later.
        drive_lock(1'b0);
        tick(); check_outs("t3_l1", 3'b000, 1'b1, ST_RUN);
        tick(); check_outs("t3_l2", 3'b000, 1'b1, ST_RUN);
        tick(); check_outs("t3_l3", 3'b111, 1'b0, ST_WAIT_LOCK);
        drive_lock(1'b1);
        tick(); check_outs("t3_r1", 3'b111, 1'b0, ST_WAIT_LOCK);
        tick(); check_outs("t3_r2", 3'b111, 1'b0, ST_WAIT_LOCK);
        tick(); check_outs("t3_r3", 3'b111, 1'b0, ST_HOLD);
        run_seq("t3", 1'b0);

        // Soft-reset pulse in RELEASE with RST_OUT=100.
        drive_sw(1'b1);
        tick(); check_outs("t4_a", 3'b111, 1'b0, ST_ASSERT);
        drive_sw(1'b0);
        tick(); check_outs("t4_w", 3'b111, 1'b0, ST_WAIT_LOCK);
        tick(); check_outs("t4_h", 3'b111, 1'b0, ST_HOLD);
        advance(21);
        check_outs("t4_k21", 3'b100, 1'b0, ST_RELEASE);
        drive_sw(1'b1);
        tick(); check_outs("t4_pulse", 3'b111, 1'b0, ST_ASSERT);
        drive_sw(1'b0);
        tick(); check_outs("t4_w2", 3'b111, 1'b0, ST_WAIT_LOCK);
        tick(); check_outs("t4_h2", 3'b111, 1'b0, ST_HOLD);
        // Soft reset and lock loss seen on the same edge: ASSERT wins.
        advance(17);
        drive_lock(1'b0);
        tick();
        tick(); check_outs("t4_k19", 3'b110, 1'b0, ST_RELEASE);
        drive_sw(1'b1);
        tick(); check_outs("t4_both", 3'b111, 1'b0, ST_ASSERT);
        drive_sw(1'b0);
        drive_lock(1'b1);
        tick(); check_outs("t4_b1", 3'b111, 1'b0, ST_WAIT_LOCK);
        tick(); check_outs("t4_b2", 3'b111, 1'b0, ST_WAIT_LOCK);
        tick(); check_outs("t4_b3", 3'b111, 1'b0, ST_HOLD);
        run_seq("t4", 1'b0);

        // Short CLR_N pulse in RUN acts before the next edge.
        #2 clr_n = 1'b0;
        #1;
        check_outs("t5_async", 3'b111, 1'b0, ST_ASSERT);
        #1 clr_n = 1'b1;
        tick(); check_outs("t5_e1", 3'b111, 1'b0, ST_WAIT_LOCK);
        tick(); check_outs("t5_e2", 3'b111, 1'b0, ST_WAIT_LOCK);
        tick(); check_outs("t5_e3", 3'b111, 1'b0, ST_HOLD);
        run_seq("t5", 1'b0);

        // Watchdog: lock absent after a CLR_N pulse.
        drive_lock(1'b0);
        #2 clr_n = 1'b0;
        #1 clr_n = 1'b1;
        tick(); check_outs("t6_e1", 3'b111, 1'b0, ST_WAIT_LOCK);
        advance(6);
        chk("t6_e7_timeout", 32'(bus.timeout), 32'(0));
        tick();
        chk("t6_e8_timeout", 32'(bus.timeout), 32'(0));
        tick();
        chk("t6_e9_timeout", 32'(bus.timeout), 32'(WDOG_ON));
        check_outs("t6_e9", 3'b111, 1'b0, ST_WAIT_LOCK);
        advance(3);
        chk("t6_e12_timeout", 32'(bus.timeout), 32'(WDOG_ON));
        drive_lock(1'b1);
        tick();
        tick(); check_outs("t6_w", 3'b111, 1'b0, ST_WAIT_LOCK);
        tick(); check_outs("t6_h", 3'b111, 1'b0, ST_HOLD);
        chk("t6_h_timeout", 32'(bus.timeout), 32'(WDOG_ON));
        run_seq("t6", WDOG_ON);
        drive_sw(1'b1);
        tick();
        chk("t6_sw_timeout", 32'(bus.timeout), 32'(0));
        check_outs("t6_sw", 3'b111, 1'b0, ST_ASSERT);
        drive_sw(1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- Generates ordered, per-stage reset releases for the Ethernet core.
- Sits directly downstream of the async-preset synchronizer flops. It consumes a PLL/MMCM lock indication and a soft reset request.
- Drives STAGES active-high reset outputs: PHY, MAC, then core/CSR. They are released one at a time, after lock has been stable for a hold-off period.
- Re-asserts all outputs on lock loss or soft reset.

Parameters:
- SYNC_STAGES, 2: flops in the LOCK synchronizer chain (>=2).
- HOLD_CYCLES, 16: cycles synchronized lock must stay high before the first release (>=1).
- STAGES, 3: number of reset outputs (>=1).
- STEP_CYCLES, 4: cycles between successive stage releases (>=1).
- WDOG_CYCLES, 1024: lock-wait watchdog limit. Used only with RESET_SEQ_WDOG_EN.

Ports:
- C, input, 1: clock.
- CLR_N, input, 1: reset. Asynchronous, active-low.
- LOCK, input, 1: PLL lock. Asynchronous to C; synchronized internally.
- SW_RST, input, 1: soft reset request. Synchronous to C; level or pulse.
- RST_OUT, output, STAGES: per-stage reset, active high. Bit 0 is released first.
- DONE, output, 1: high while all stages are released.
- TIMEOUT, output, 1: lock-wait watchdog flag. Tied 0 without RESET_SEQ_WDOG_EN.

Behaviour:
- Reset: CLR_N is asynchronous and active-low.
  - While CLR_N=0: RST_OUT all ones, DONE=0, TIMEOUT=0, state ASSERT, all counters 0, sync chain all 0.
  - Assertion takes effect immediately, mid-sequence included.
- Sync chain: LOCK passes through SYNC_STAGES flops, giving lock_s. This adds SYNC_STAGES edges of latency.
- States and transitions:
  - ASSERT: all RST_OUT=1, DONE=0. Unconditionally moves to WAIT_LOCK next edge.
  - WAIT_LOCK: when lock_s=1, moves to HOLD with hold counter cleared.
  - HOLD: hold counter increments each edge with lock_s=1.
    - lock_s=0: go to WAIT_LOCK, counter cleared, no output change.
    - On the HOLD_CYCLES-th edge after HOLD entry: RST_OUT[0]<=0, step counter cleared, idx<=1, go to RELEASE.
    - If STAGES=1: go straight to RUN instead, with DONE<=1 on that same edge.
  - RELEASE: step counter increments each edge.
    - On the STEP_CYCLES-th edge: RST_OUT[idx]<=0, idx++, counter cleared.
    - The edge that clears RST_OUT[STAGES-1] also sets DONE<=1 and enters RUN.
    - Stages release strictly in ascending order. No two bits clear on the same edge.
  - RUN: holds RST_OUT=0 and DONE=1.
- Lock loss: lock_s=0 in RELEASE or RUN. On the next edge: all RST_OUT<=1, DONE<=0, counters cleared, go to WAIT_LOCK.
- SW_RST=1 in any state: on the next edge, all RST_OUT<=1, DONE<=0, counters cleared, go to ASSERT.
  - Held SW_RST keeps the block in ASSERT.
  - SW_RST has priority over lock loss when both occur on the same edge.
- Counters: hold, step and watchdog widths are $clog2(limit+1). Counters never wrap; they saturate or clear on state exit.
- Outputs are registered only. There is no combinational path from any input to any output.

Optional Feature:
- Macro RESET_SEQ_WDOG_EN.
- Defined:
  - A watchdog counter runs while in WAIT_LOCK.
  - After WDOG_CYCLES consecutive edges in WAIT_LOCK, TIMEOUT<=1 (sticky). The state stays WAIT_LOCK and RST_OUT stays all ones.
  - The watchdog counter saturates.
  - TIMEOUT clears only on CLR_N=0 or SW_RST=1.
  - Leaving WAIT_LOCK clears the watchdog counter but not TIMEOUT.
- Undefined: no watchdog logic; TIMEOUT constant 0.

Test Plan:
- Defaults, LOCK=1 before CLR_N rises; CLR_N rises before edge 1.
  - lock_s=1 after edge 2; HOLD entered at edge 3.
  - RST_OUT goes 3'b111 -> 3'b110 at edge 19 -> 3'b100 at edge 23 -> 3'b000 at edge 27, with DONE=1 at edge 27.
- LOCK drops for 1 cycle at HOLD count 10 -> no output change, hold count restarts. RST_OUT[0] clears 16 edges after re-entry to HOLD.
- In RUN, LOCK falls -> SYNC_STAGES+1 edges later RST_OUT=3'b111 and DONE=0. After LOCK rises again, the full sequence repeats with identical spacing (16/4/4).
- SW_RST 1-cycle pulse during RELEASE (RST_OUT=3'b100) -> next edge RST_OUT=3'b111, state ASSERT.
  - Same-edge SW_RST and lock loss -> ASSERT, not WAIT_LOCK.
- CLR_N pulsed low for less than one clock period while in RUN -> RST_OUT=3'b111 and DONE=0 asynchronously, before the next edge. The sequence then restarts.
- RESET_SEQ_WDOG_EN, WDOG_CYCLES=8, LOCK=0:
  - TIMEOUT=1 on the 8th edge in WAIT_LOCK, and stays 1 after LOCK rises and the sequence completes.
  - SW_RST pulse clears TIMEOUT.
  - Without the macro, TIMEOUT stays 0 throughout.
